// File: rtl/delta_spike_encoder.sv
// delta_spike_encoder
// Multi-channel delta-modulation spike encoder. Each accepted sample vector is
// compared per channel against a tracked reference level. A change beyond the
// threshold emits an ON or OFF event. Each channel also has a first-sample
// priming step and a refractory window counted in accepted samples.
// The output side is a single registered stage with pass-through ready.
module delta_spike_encoder #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int REFR_W   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [WIDTH-1:0]             threshold,
    input  logic                         off_en,
    input  logic [REFR_W-1:0]            refractory,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*CHANNELS-1:0]        out_spike,
    output logic                         out_any
);

    // Per-channel tracking state
    logic [WIDTH-1:0]         ref_lvl     [CHANNELS];
    logic [CHANNELS-1:0]      primed;
    logic [REFR_W-1:0]        rcnt        [CHANNELS];

    // Next-state values, applied only when a sample is accepted
    logic [WIDTH-1:0]         ref_next    [CHANNELS];
    logic [CHANNELS-1:0]      primed_next;
    logic [REFR_W-1:0]        rcnt_next   [CHANNELS];
    logic [2*CHANNELS-1:0]    spike_next;

    // One extra bit keeps the full +/-(2^WIDTH-1) difference without wrap
    logic signed [WIDTH:0]    diff        [CHANNELS];
    logic signed [WIDTH:0]    pos_thr;
    logic signed [WIDTH:0]    neg_thr;

    logic                     accept;

    // The output register frees up whenever it is empty or retiring this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Signed threshold bounds; -threshold always fits in WIDTH+1 bits
    always_comb begin
        pos_thr = $signed({1'b0, threshold});
        neg_thr = -pos_thr;
    end

    // Per-channel signed difference between the incoming sample and the reference
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            diff[c] = $signed({1'b0, in_data[c*WIDTH +: WIDTH]})
                    - $signed({1'b0, ref_lvl[c]});
        end
    end

    // Per-channel update rules in priority order: prime, refractory, ON, OFF, idle
    always_comb begin
        ref_next    = ref_lvl;
        primed_next = primed;
        rcnt_next   = rcnt;
        spike_next  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!primed[c]) begin
                ref_next[c]    = in_data[c*WIDTH +: WIDTH];
                primed_next[c] = 1'b1;
            end else if (rcnt[c] != '0) begin
                rcnt_next[c] = rcnt[c] - REFR_W'(1);
            end else if (diff[c] > pos_thr) begin
                spike_next[2*c] = 1'b1;
                ref_next[c]     = in_data[c*WIDTH +: WIDTH];
                rcnt_next[c]    = refractory;
            end else if (off_en && (diff[c] < neg_thr)) begin
                spike_next[2*c+1] = 1'b1;
                ref_next[c]       = in_data[c*WIDTH +: WIDTH];
                rcnt_next[c]      = refractory;
            end
        end
    end

    // Channel state advances only on accepted samples, so backpressure freezes it
    always_ff @(posedge clk) begin
        if (reset) begin
            primed <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                ref_lvl[c] <= '0;
                rcnt[c]    <= '0;
            end
        end else if (accept) begin
            primed  <= primed_next;
            ref_lvl <= ref_next;
            rcnt    <= rcnt_next;
        end
    end

    // Output stage: load on accept, clear valid on retire, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_spike <= '0;
            out_any   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_spike <= spike_next;
            out_any   <= |spike_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_delta_spike_encoder.sv
// Self-checking bench for delta_spike_encoder: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_delta_spike_encoder;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int REFR_W   = 4;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0]          threshold = '0;
    logic                      off_en = 1'b0;
    logic [REFR_W-1:0]         refractory = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [2*CHANNELS-1:0]     out_spike;
    logic                      out_any;

    delta_spike_encoder #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .REFR_W(REFR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .threshold(threshold), .off_en(off_en), .refractory(refractory),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_spike(out_spike), .out_any(out_any)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: plain integers per channel plus one held output slot
    int   m_ref    [CHANNELS];
    bit   m_primed [CHANNELS];
    int   m_rcnt   [CHANNELS];
    bit   exp_valid;
    logic [2*CHANNELS-1:0] exp_spike;
    int   n_vec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_ref[c] = 0; m_primed[c] = 0; m_rcnt[c] = 0;
        end
        exp_valid = 0;
        exp_spike = '0;
    endtask

    // Apply the encoding rules to one accepted sample vector
    task automatic model_sample(input logic [31:0] d, input int thr, input bit oe, input int refr);
        exp_spike = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            int v;
            int dl;
            v  = int'(d[c*WIDTH +: WIDTH]);
            dl = v - m_ref[c];
            if (!m_primed[c]) begin
                m_ref[c] = v; m_primed[c] = 1;
            end else if (m_rcnt[c] > 0) begin
                m_rcnt[c] = m_rcnt[c] - 1;
            end else if (dl > thr) begin
                exp_spike[2*c] = 1'b1; m_ref[c] = v; m_rcnt[c] = refr;
            end else if (oe && dl < -thr) begin
                exp_spike[2*c+1] = 1'b1; m_ref[c] = v; m_rcnt[c] = refr;
            end
        end
    endtask

    // One clock cycle: drive, check against model, advance model, clock
    task automatic cyc(input bit v, input logic [31:0] d, input int thr, input bit oe,
                       input int refr, input bit ordy);
        logic [31:0] thr_v;
        logic [31:0] refr_v;
        bit acc;
        thr_v  = thr;
        refr_v = refr;
        in_valid   = v;
        in_data    = d;
        threshold  = thr_v[WIDTH-1:0];
        off_en     = oe;
        refractory = refr_v[REFR_W-1:0];
        out_ready  = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!exp_valid || ordy));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_spike", 32'(out_spike), 32'(exp_spike));
            chk("out_any", 32'(out_any), 32'(|exp_spike));
        end
        acc = v && (!exp_valid || ordy);
        if (acc) begin
            model_sample(d, thr, oe, refr);
            exp_valid = 1;
            n_vec++;
        end else if (ordy) begin
            exp_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = 0;
        out_ready = 0;
        reset     = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_spike", 32'(out_spike), 0);
        chk("rst_out_any", 32'(out_any), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        logic [31:0] rd;
        n_vec = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Priming then a spike above threshold
        cyc(1, 32'd100, 10, 0, 0, 1);
        chk("tp_prime0", 32'(out_spike), 0);
        cyc(1, 32'd100, 10, 0, 0, 1);
        chk("tp_prime1", 32'(out_spike), 0);
        cyc(1, 32'd111, 10, 0, 0, 1);
        chk("tp_on", 32'(out_spike), 32'h1);

        // Strict boundary and OFF gating
        do_reset();
        cyc(1, 32'd50, 5, 1, 0, 1);
        cyc(1, 32'd55, 5, 1, 0, 1);
        chk("tp_eq_thr", 32'(out_spike), 0);
        cyc(1, 32'd44, 5, 0, 0, 1);
        chk("tp_off_dis", 32'(out_spike), 0);
        cyc(1, 32'd44, 5, 1, 0, 1);
        chk("tp_off", 32'(out_spike), 32'h2);

        // Refractory window over a ramp
        do_reset();
        cyc(1, 32'd0, 1, 0, 2, 1);
        chk("tp_ramp1", 32'(out_spike), 0);
        cyc(1, 32'd10, 1, 0, 2, 1);
        chk("tp_ramp2", 32'(out_spike), 32'h1);
        cyc(1, 32'd20, 1, 0, 2, 1);
        chk("tp_ramp3", 32'(out_spike), 0);
        cyc(1, 32'd30, 1, 0, 2, 1);
        chk("tp_ramp4", 32'(out_spike), 0);
        cyc(1, 32'd40, 1, 0, 2, 1);
        chk("tp_ramp5", 32'(out_spike), 32'h1);

        // Full-scale swings
        do_reset();
        cyc(1, 32'd0, 254, 1, 0, 1);
        cyc(1, 32'd255, 254, 1, 0, 1);
        chk("tp_ext_on", 32'(out_spike), 32'h1);
        cyc(1, 32'd0, 254, 1, 0, 1);
        chk("tp_ext_off", 32'(out_spike), 32'h2);

        // Backpressure: hold out_ready low with a pending input
        cyc(1, 32'h0A0B0C0D, 3, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 3, 1, 1, 0);
        chk("tp_bp_ready", 32'(in_ready), 0);
        for (int i = 0; i < 20; i++) cyc(1, $urandom, 20, 1, 1, 1);

        // Reset with a held result
        cyc(1, 32'h11223344, 2, 1, 0, 0);
        chk("tp_held", 32'(out_valid), 1);
        do_reset();
        cyc(1, 32'hFFFFFFFF, 0, 1, 0, 1);
        cyc(0, 32'h0, 0, 1, 0, 1);
        chk("tp_rst_prime", 32'(out_spike), 0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            rd = $urandom;
            cyc($urandom_range(0, 3) != 0, rd, int'($urandom_range(0, 80)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 0, 0, 0, 1);
        chk("vec_count_nonzero", 32'(n_vec > 100), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delta_spike_encoder.md
# delta_spike_encoder

Multi-channel delta-modulation spike encoder for the sensor front end. Each accepted sample vector is compared per channel against a stored reference level. ON/OFF spike events are emitted when the change exceeds a programmable threshold. The block adds per-channel reference tracking, a first-sample priming rule, a refractory period, and valid/ready handshakes on both sides. It sits between the ADC sample stream and the spike packetiser.

## Interface
Parameters:
- WIDTH, 8, sample and threshold width (unsigned)
- CHANNELS, 4, number of parallel channels
- REFR_W, 4, width of the refractory count

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  sample vector valid
- in_ready  output  1  block can accept a sample vector this cycle
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH], unsigned
- threshold  input  WIDTH  spike threshold, unsigned; sampled on acceptance
- off_en  input  1  enables OFF spikes; sampled on acceptance
- refractory  input  REFR_W  number of accepted samples suppressed after a spike; sampled on acceptance
- out_valid  output  1  spike vector valid
- out_ready  input  1  downstream accepts the spike vector
- out_spike  output  2*CHANNELS  bit 2c = ON for channel c, bit 2c+1 = OFF for channel c
- out_any  output  1  OR of all out_spike bits

## Operation
- Acceptance: a sample vector is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (single output register with pass-through ready).
- Per-channel state: ref[c] (WIDTH), primed[c] (1 bit), rcnt[c] (REFR_W).
- Difference: diff = {1'b0,data} - {1'b0,ref}, computed as a signed WIDTH+1-bit value. No wrap-around; the full range is ±(2^WIDTH-1).
- Per accepted sample, for each channel c, the first matching rule applies:
  - Not primed: ref <= data, primed <= 1, no spike.
  - rcnt != 0: rcnt <= rcnt-1, no spike, ref unchanged.
  - diff > threshold: ON; ref <= data; rcnt <= refractory.
  - off_en && diff < -threshold: OFF; ref <= data; rcnt <= refractory.
  - Otherwise: no spike, ref unchanged.
- Comparisons are strict, so diff == ±threshold produces no spike. threshold = 0 makes any nonzero change spike.
- ON and OFF are mutually exclusive per channel. With off_en = 0, a negative change never spikes and never updates ref.
- refractory = 0 means no suppression. A refractory window counts accepted samples, not clock cycles.
- A channel's rcnt changes only when a sample is accepted.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_spike = 0, out_any = 0. All ref = 0, primed = 0, rcnt = 0.
- Reset mid-operation: any held output is discarded (out_valid = 0 on the next cycle) and all channels return to unprimed.
- Latency: 1 cycle. The result of a sample accepted in cycle N is presented with out_valid = 1 in cycle N+1.
- Hold rule: out_valid, out_spike and out_any stay stable until out_valid && out_ready.
- Simultaneous out_ready and in_valid while out_valid = 1: the old result retires and the new result loads in the same cycle. Full throughput is one vector per cycle.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and per-channel state is frozen.
- An output vector is produced for every accepted sample, including priming and all-zero vectors.

## Test plan
- Priming: after reset, accept ch0 = 100, then 100 -> both out_spike = 0; ref0 = 100. Accept 111 with threshold = 10 -> out_spike[0] = 1, ref0 = 111.
- Boundary and OFF: ref = 50, threshold = 5, off_en = 1. Data 55 -> no spike. Data 44 -> bit1 = 1. Same 44 with off_en = 0 -> no spike, ref stays 50.
- Refractory: refractory = 2, threshold = 1, ramp 0, 10, 20, 30, 40 -> spikes on samples 2 and 5 only. rcnt counts 2, 1, 0 across samples 3-4.
- Extremes: WIDTH = 8, ref = 0, data = 255, threshold = 254 -> ON. Then data = 0, threshold = 254, off_en = 1 -> OFF, with no overflow.
- Handshake: hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs stable. Then out_ready = 1 continuously -> one vector per cycle, no loss or duplication (scoreboard vs model).
- Reset mid-stream: assert reset while out_valid = 1 -> out_valid = 0 next cycle. The next sample primes and produces no spike.
